// File: rtl/input_conditioner_array.sv
// Multi-channel input conditioner: 2-flop synchroniser, debounce and registered edge pulses per channel.
// Each channel is independent; an optional per-channel bypass skips the debounce window.
module input_conditioner_array #(
    parameter int unsigned          CHANNELS     = 4,
    parameter int unsigned          WAITTIME     = 3,
    parameter int unsigned          COUNTERWIDTH = 3,
    parameter logic [CHANNELS-1:0]  RESETVAL     = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] noisysignal,
    input  logic [CHANNELS-1:0] bypass,
    output logic [CHANNELS-1:0] conditioned,
    output logic [CHANNELS-1:0] positiveedge,
    output logic [CHANNELS-1:0] negativeedge,
    output logic [CHANNELS-1:0] syncout
);

    localparam logic [COUNTERWIDTH-1:0] WAIT_C = COUNTERWIDTH'(WAITTIME);
    localparam logic [COUNTERWIDTH-1:0] ONE_C  = COUNTERWIDTH'(1);

    logic [CHANNELS-1:0] sync0;
    logic [CHANNELS-1:0] sync1;

    // Two-stage synchroniser for all channels
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync0 <= RESETVAL;
            sync1 <= RESETVAL;
        end else begin
            sync0 <= noisysignal;
            sync1 <= sync0;
        end
    end

    assign syncout = sync1;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [COUNTERWIDTH-1:0] count_q;
        logic [COUNTERWIDTH-1:0] count_d;
        logic                    cond_q;
        logic                    cond_d;
        logic                    rise_q;
        logic                    rise_d;
        logic                    fall_q;
        logic                    fall_d;

        // Any match with the committed level restarts the count; a full mismatch window commits
        always_comb begin
            count_d = '0;
            cond_d  = cond_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            if (sync1[i] != cond_q) begin
                if (bypass[i] || (count_q == WAIT_C)) begin
                    cond_d = sync1[i];
                    rise_d = sync1[i];
                    fall_d = ~sync1[i];
                end else begin
                    count_d = count_q + ONE_C;
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                count_q <= '0;
                cond_q  <= RESETVAL[i];
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                count_q <= count_d;
                cond_q  <= cond_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        assign conditioned[i]  = cond_q;
        assign positiveedge[i] = rise_q;
        assign negativeedge[i] = fall_q;
    end

endmodule

// File: tb/tb_input_conditioner_array.sv
// Bench for input_conditioner_array: two instances (WAITTIME 3 and 0) share random/directed stimulus;
// a window-based reference model feeds a scoreboard drained by a negedge monitor.
module tb_input_conditioner_array;

    localparam int unsigned CH  = 4;
    localparam int unsigned NI  = 2;
    localparam int          WT0 = 3;
    localparam int          WT1 = 0;
    localparam logic [CH-1:0] RV0 = 4'b0000;
    localparam logic [CH-1:0] RV1 = 4'b1010;

    typedef struct packed {
        logic [CH-1:0] c;
        logic [CH-1:0] p;
        logic [CH-1:0] n;
        logic [CH-1:0] s;
    } obs_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] noisysignal = '0;
    logic [CH-1:0] bypass = '0;
    logic [CH-1:0] cond [NI];
    logic [CH-1:0] pos  [NI];
    logic [CH-1:0] neg  [NI];
    logic [CH-1:0] syn  [NI];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    input_conditioner_array #(
        .CHANNELS(CH), .WAITTIME(WT0), .COUNTERWIDTH(3), .RESETVAL(RV0)
    ) dut0 (
        .clk(clk), .reset(reset), .noisysignal(noisysignal), .bypass(bypass),
        .conditioned(cond[0]), .positiveedge(pos[0]), .negativeedge(neg[0]), .syncout(syn[0])
    );

    input_conditioner_array #(
        .CHANNELS(CH), .WAITTIME(WT1), .COUNTERWIDTH(1), .RESETVAL(RV1)
    ) dut1 (
        .clk(clk), .reset(reset), .noisysignal(noisysignal), .bypass(bypass),
        .conditioned(cond[1]), .positiveedge(pos[1]), .negativeedge(neg[1]), .syncout(syn[1])
    );

    // Reference model: synchroniser as a two-sample delay, debounce as "last WAITTIME+1
    // synchronised samples all disagree with the committed level"
    logic [CH-1:0] m_s0   [NI];
    logic [CH-1:0] m_s1   [NI];
    logic [CH-1:0] m_cond [NI];
    logic [CH-1:0] m_pos  [NI];
    logic [CH-1:0] m_neg  [NI];
    logic [15:0]   hv     [NI][CH];
    int            hlen   [NI][CH];
    obs_t          sbq    [NI][$];

    function automatic int wt(input int i);
        return (i == 0) ? WT0 : WT1;
    endfunction

    function automatic logic [CH-1:0] rv(input int i);
        return (i == 0) ? RV0 : RV1;
    endfunction

    function automatic void model_reset(input int i);
        m_s0[i]   = rv(i);
        m_s1[i]   = rv(i);
        m_cond[i] = rv(i);
        m_pos[i]  = '0;
        m_neg[i]  = '0;
        for (int c = 0; c < CH; c++) begin
            hv[i][c]   = '0;
            hlen[i][c] = 0;
        end
    endfunction

    function automatic void model_step(input int i);
        logic [15:0]   mask;
        logic [CH-1:0] nc;
        logic [CH-1:0] np;
        logic [CH-1:0] nn;
        logic          cur;
        logic          win_ok;
        logic          commit;
        mask = 16'((32'd1 << (wt(i) + 1)) - 32'd1);
        for (int c = 0; c < CH; c++) begin
            cur = m_s1[i][c];
            hv[i][c] = {hv[i][c][14:0], cur};
            if (hlen[i][c] < 16) hlen[i][c]++;
            win_ok = (hlen[i][c] >= wt(i) + 1) &&
                     (((hv[i][c] ^ {16{m_cond[i][c]}}) & mask) == mask);
            commit = (cur != m_cond[i][c]) && (bypass[c] || win_ok);
            np[c] = commit && cur;
            nn[c] = commit && !cur;
            nc[c] = commit ? cur : m_cond[i][c];
        end
        m_cond[i] = nc;
        m_pos[i]  = np;
        m_neg[i]  = nn;
        m_s1[i]   = m_s0[i];
        m_s0[i]   = noisysignal;
    endfunction

    function automatic void check(input string nm, input int i,
                                  input logic [CH-1:0] act, input logic [CH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t actual=%b required=%b", nm, i, $time, act, exp);
        end
    endfunction

    // Stimulus side of the scoreboard: predict every edge
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (reset) model_reset(i);
            else       model_step(i);
            sbq[i].push_back(obs_t'{c: m_cond[i], p: m_pos[i], n: m_neg[i], s: m_s1[i]});
        end
    end

    // Monitor: compare DUT outputs away from the active edge
    always @(negedge clk) begin
        obs_t e;
        for (int i = 0; i < NI; i++) begin
            if (sbq[i].size() != 0) begin
                e = sbq[i].pop_front();
                check("conditioned",  i, cond[i], e.c);
                check("positiveedge", i, pos[i],  e.p);
                check("negativeedge", i, neg[i],  e.n);
                check("syncout",      i, syn[i],  e.s);
                check("both_edges",   i, pos[i] & neg[i], '0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Asynchronous assertion is checked without waiting for a clock edge
    task automatic apply_reset(input int cycles);
        reset = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            check("rst_conditioned",  i, cond[i], rv(i));
            check("rst_positiveedge", i, pos[i],  '0);
            check("rst_negativeedge", i, neg[i],  '0);
            check("rst_syncout",      i, syn[i],  rv(i));
            model_reset(i);
            sbq[i].delete();
        end
        repeat (cycles) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        int rate;
        tick(1);
        apply_reset(3);
        tick(10);

        noisysignal[0] = 1'b1;
        tick(10);

        for (int k = 0; k < 4; k++) begin
            noisysignal[1] = (k % 2 == 0);
            tick(2);
        end
        noisysignal[1] = 1'b1;
        tick(10);

        noisysignal[2] = 1'b1;
        tick(10);
        noisysignal[2] = 1'b0;
        tick(10);

        bypass[3] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            noisysignal[3] = ~noisysignal[3];
            tick(3);
            if (k == 4) bypass[3] = 1'b0;
        end
        tick(10);

        // ch0 falls, reset lands with the debounce count at 2, input back high across release
        noisysignal[0] = 1'b0;
        tick(4);
        noisysignal[0] = 1'b1;
        apply_reset(2);
        tick(12);

        noisysignal = '0;
        tick(12);
        noisysignal = '1;
        tick(12);
        noisysignal[2] = 1'b0;
        tick(1);
        noisysignal[2] = 1'b1;
        tick(10);

        rate = 4;
        for (int n = 0; n < 3000; n++) begin
            if (n % 100 == 0) rate = int'($urandom_range(1, 10));
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, rate - 1) == 0) noisysignal[c] = ~noisysignal[c];
            if ($urandom_range(0, 31) == 0) bypass = CH'($urandom);
            if ($urandom_range(0, 399) == 0) apply_reset(int'($urandom_range(1, 3)));
            else tick(1);
        end
        bypass = '0;
        tick(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
